// File: rtl/sipo_pkg.sv
// Shared types, constants and helpers for the serial-in/parallel-out frame receiver.
package sipo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_HOLD   = 2'd3
  } sipo_state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Even parity: a mismatch means the received bit disagrees with the XOR of the data.
  function automatic logic parity_mismatch(input logic [31:0] data, input logic par_bit);
    return (^data) != par_bit;
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Saturating bit counter for the frame receiver; counts accepted samples up to WIDTH.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          increment,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] MAX_COUNT = CW'(WIDTH);

  logic [CW-1:0] count_r;

  // Count register: clear wins over increment, and the value never passes WIDTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (increment && (count_r != MAX_COUNT)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/sipo_frame_rx.sv
// MSB-first serial-to-parallel frame receiver with a ready/valid output hold stage.
// Optional even-parity bit after each frame is enabled by defining SIPO_PARITY_EN.
module sipo_frame_rx
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             parity_err
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  sipo_state_t      state_r, state_next_s;
  logic [WIDTH-1:0] sreg_r, sreg_next_s, dout_r;
  logic             dout_valid_r, busy_r, load_s;
  logic             clear_s, shift_en_s, last_s;
  logic [CW-1:0]    count_s;

  sipo_bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_bit_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_s),
    .increment (shift_en_s),
    .count     (count_s)
  );

  assign clear_s     = (state_r == ST_IDLE) && start;
  assign shift_en_s  = (state_r == ST_SHIFT) && din_valid;
  assign last_s      = shift_en_s && (count_s == LAST_IDX);
  assign sreg_next_s = shift_en_s ? {sreg_r[WIDTH-2:0], din} : sreg_r;

  // Next-state decode; load_s marks the cycle whose edge moves the frame into dout.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_SHIFT;
        else       state_next_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (last_s) begin
`ifdef SIPO_PARITY_EN
          state_next_s = ST_PARITY;
`else
          state_next_s = ST_HOLD;
          load_s       = 1'b1;
`endif
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_PARITY: begin
`ifdef SIPO_PARITY_EN
        if (din_valid) begin
          state_next_s = ST_HOLD;
          load_s       = 1'b1;
        end else begin
          state_next_s = ST_PARITY;
        end
`else
        state_next_s = ST_IDLE;
`endif
      end
      ST_HOLD: begin
        if (dout_ready) state_next_s = ST_IDLE;
        else            state_next_s = ST_HOLD;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, shift register and output registers; dout keeps its frame after the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      sreg_r       <= {WIDTH{1'b0}};
      dout_r       <= {WIDTH{1'b0}};
      dout_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r <= state_next_s;
      sreg_r  <= clear_s ? {WIDTH{1'b0}} : sreg_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      if (load_s) begin
        dout_r       <= sreg_next_s;
        dout_valid_r <= 1'b1;
      end else if ((state_r == ST_HOLD) && dout_ready) begin
        dout_valid_r <= 1'b0;
      end else begin
        dout_valid_r <= dout_valid_r;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  logic parity_err_r;

  // Parity flag is captured on the same edge that loads dout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err_r <= 1'b0;
    end else if (load_s) begin
      parity_err_r <= parity_mismatch(32'(sreg_r), din);
    end else begin
      parity_err_r <= parity_err_r;
    end
  end

  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Self-checking bench for sipo_frame_rx: directed scenarios plus randomized frames
// checked against a bit-list reference model. Follows SIPO_PARITY_EN when defined.
module tb_sipo_frame_rx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, din, din_valid, start, dout_ready;
  logic [W-1:0] dout;
  logic         dout_valid, busy, parity_err;

  int checks   = 0;
  int failures = 0;

  sipo_frame_rx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .start      (start),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    din        = 1'b0;
    din_valid  = 1'b0;
    start      = 1'b0;
    dout_ready = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      din_valid = 1'b0;
      din       = 1'($urandom_range(0, 1));
      tick();
    end
    din_valid = 1'b1;
    din       = b;
    tick();
    din_valid = 1'b0;
    din       = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_ack();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
  endtask

  // Reference: the frame is the first W received bits read as a binary number, first bit most significant.
  function automatic logic [W-1:0] model_frame(input logic bits[$]);
    longint v = 0;
    for (int i = 0; i < W; i++) v = v * 2 + longint'(bits[i]);
    return W'(v);
  endfunction

  function automatic logic model_perr(input logic bits[$], input logic pbit);
    int ones = 0;
    for (int i = 0; i < W; i++) ones += int'(bits[i]);
`ifdef SIPO_PARITY_EN
    return (ones % 2) != int'(pbit);
`else
    return (ones < 0) && pbit;
`endif
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout: got %h expected %h", dout, 8'h00); end
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_dout_valid: got %b expected 0", dout_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    logic bits[$];
    bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    do_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b expected 1", busy); end
    for (int i = 0; i < W - 1; i++) send_bit(bits[i], 0);
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %b expected 0", dout_valid); end
    send_bit(bits[W-1], 0);
`ifdef SIPO_PARITY_EN
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_before_parity: got %b expected 0", dout_valid); end
    send_bit(1'b0, 0);
`endif
    checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b expected 1", dout_valid); end
    checks++; if (dout !== 8'hB2) begin failures++; $display("FAIL basic_dout: got %h expected %h", dout, 8'hB2); end
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL basic_parity_err: got %b expected 0", parity_err); end
    do_ack();
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL basic_ack_valid: got %b expected 0", dout_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_ack_busy: got %b expected 0", busy); end
  endtask

  task automatic test_gaps();
    logic bits[$];
    logic [W-1:0] exp_v;
    bits  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_v = model_frame(bits);
    do_start();
    for (int i = 0; i < 4; i++) send_bit(bits[i], 0);
    for (int i = 4; i < W; i++) send_bit(bits[i], (i == 4) ? 3 : 0);
`ifdef SIPO_PARITY_EN
    send_bit(1'b0, 1);
`endif
    checks++; if (dout !== exp_v) begin failures++; $display("FAIL gaps_dout: got %h expected %h", dout, exp_v); end
    for (int c = 0; c < 3; c++) begin
      din_valid = 1'b1;
      din       = 1'($urandom_range(0, 1));
      tick();
      checks++; if (dout !== exp_v || dout_valid !== 1'b1) begin failures++; $display("FAIL gaps_extra_samples: got %h/%b expected %h/1", dout, dout_valid, exp_v); end
    end
    din_valid = 1'b0;
    do_ack();
  endtask

  task automatic test_hold();
    logic bits[$];
    logic [W-1:0] exp_v;
    for (int i = 0; i < W; i++) bits.push_back(1'($urandom_range(0, 1)));
    exp_v = model_frame(bits);
    do_start();
    for (int i = 0; i < W; i++) send_bit(bits[i], 0);
`ifdef SIPO_PARITY_EN
    send_bit(1'b0, 0);
`endif
    for (int c = 0; c < 5; c++) begin
      start = (c == 1 || c == 3);
      tick();
      checks++; if (dout !== exp_v || dout_valid !== 1'b1) begin failures++; $display("FAIL hold_stable: got %h/%b expected %h/1", dout, dout_valid, exp_v); end
    end
    start      = 1'b1;
    dout_ready = 1'b1;
    tick();
    start      = 1'b0;
    dout_ready = 1'b0;
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL hold_release_valid: got %b expected 0", dout_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_release_busy: got %b expected 0", busy); end
    checks++; if (dout !== exp_v) begin failures++; $display("FAIL hold_retain_dout: got %h expected %h", dout, exp_v); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_start_ignored: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic bits[$];
    bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    do_start();
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (dout !== 8'h00 || dout_valid !== 1'b0 || busy !== 1'b0 || parity_err !== 1'b0) begin
      failures++; $display("FAIL reset_mid_async: got dout=%h valid=%b busy=%b perr=%b expected all 0", dout, dout_valid, busy, parity_err);
    end
    #2 rst = 1'b0;
    tick();
    do_start();
    for (int i = 0; i < W; i++) send_bit(bits[i], 0);
`ifdef SIPO_PARITY_EN
    send_bit(1'b0, 0);
`endif
    checks++; if (dout !== 8'h5A || dout_valid !== 1'b1) begin failures++; $display("FAIL reset_mid_next_frame: got %h/%b expected %h/1", dout, dout_valid, 8'h5A); end
    do_ack();
  endtask

  task automatic test_start_overlap();
    logic bits[$];
    bits      = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    start     = 1'b1;
    din_valid = 1'b1;
    din       = 1'b1;
    tick();
    start     = 1'b0;
    din_valid = 1'b0;
    din       = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL overlap_busy: got %b expected 1", busy); end
    for (int i = 0; i < W; i++) send_bit(bits[i], 0);
`ifdef SIPO_PARITY_EN
    send_bit(1'b0, 0);
`endif
    checks++; if (dout !== 8'h3C || dout_valid !== 1'b1) begin failures++; $display("FAIL overlap_dout: got %h/%b expected %h/1", dout, dout_valid, 8'h3C); end
    do_ack();
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity();
    logic bits[$];
    bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int p = 0; p < 2; p++) begin
      do_start();
      for (int i = 0; i < W; i++) send_bit(bits[i], 0);
      send_bit(1'(p), 0);
      checks++; if (parity_err !== 1'(p) || dout !== 8'hB2) begin failures++; $display("FAIL parity_bit%0d: got perr=%b dout=%h expected perr=%0d dout=b2", p, parity_err, dout, p); end
      do_ack();
    end
  endtask
`endif

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      logic bits[$];
      logic [W-1:0] exp_v;
      logic pbit, exp_perr;
      int wait_cycles;
      bits.delete();
      for (int i = 0; i < W; i++) bits.push_back(1'($urandom_range(0, 1)));
      pbit     = 1'($urandom_range(0, 1));
      exp_v    = model_frame(bits);
      exp_perr = model_perr(bits, pbit);
      do_start();
      for (int i = 0; i < W; i++) send_bit(bits[i], $urandom_range(0, 3));
`ifdef SIPO_PARITY_EN
      send_bit(pbit, $urandom_range(0, 2));
`endif
      wait_cycles = $urandom_range(0, 3);
      for (int c = 0; c <= wait_cycles; c++) begin
        checks++; if (dout !== exp_v || dout_valid !== 1'b1 || parity_err !== exp_perr) begin
          failures++; $display("FAIL random_frame%0d: got %h/%b/%b expected %h/1/%b", f, dout, dout_valid, parity_err, exp_v, exp_perr);
        end
        if (c < wait_cycles) tick();
      end
      do_ack();
      checks++; if (busy !== 1'b0 || dout_valid !== 1'b0) begin failures++; $display("FAIL random_release%0d: got busy=%b valid=%b expected 0/0", f, busy, dout_valid); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_gaps();
    test_hold();
    test_reset_mid();
    test_start_overlap();
`ifdef SIPO_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
